dcnn_load_ctrl: RTL and testbench
=================================

// Module: dcnn_load_ctrl
// PURPOSE
//  Sequences bulk loading of 16-bit DCNN words (feature maps, filter weights) from a
//  streaming word source into on-chip buffer RAM. Parses a length header, generates
//  buffer write addresses from a base, and reports completion and errors.
//  Sits between the word-source front end and the image/weight buffer write port.
// PARAMETERS
//  DATA_W     16    word width; header, payload and checksum words are all DATA_W bits
//  ADDR_W     13    buffer address width
//  MAX_WORDS  4096  largest legal payload length; must be <= 2**ADDR_W
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous reset, active-low
//  start        in   1       1-cycle pulse: begin a load; ignored while busy=1
//  abort        in   1       synchronous abort; returns the block to IDLE
//  base_addr    in   ADDR_W  first buffer address; sampled when start is accepted
//  in_valid     in   1       source word valid
//  in_data      in   DATA_W  source word
//  in_ready     out  1       controller accepts in_data this cycle
//  mem_we       out  1       buffer write enable
//  mem_addr     out  ADDR_W  buffer write address
//  mem_wdata    out  DATA_W  buffer write data
//  busy         out  1       a load is in progress (HDR/DATA/CSUM/DONE)
//  done         out  1       1-cycle pulse at load end
//  err          out  1       sticky error flag; cleared on next accepted start
//  words_loaded out  ADDR_W+1  payload words written in the current/last load
// BEHAVIOUR
//  - Reset: state=IDLE; every output is 0. Reset mid-load discards that load.
//  - Handshake: a word transfers when in_valid && in_ready. in_ready=1 only in
//    HDR, DATA and CSUM; it is a registered function of state, not of in_valid.
//  - FSM: IDLE -> HDR -> DATA -> [CSUM] -> DONE -> IDLE.
//    IDLE: start=1 -> latch base_addr, clear err/words_loaded/checksum, go HDR.
//    HDR: accepted word is N. N==0 or N>MAX_WORDS -> err=1, go DONE.
//      Otherwise latch N, idx=0, go DATA.
//    DATA: each accepted word -> next cycle mem_we=1, mem_addr=(base+idx) mod
//      2**ADDR_W (wraps), mem_wdata=word; idx++, words_loaded++.
//      Write latency is 1 cycle; back-to-back words give back-to-back writes.
//      After the N-th word -> CSUM if CHECKSUM_EN is defined, else DONE.
//    DONE: done=1 for exactly one cycle; busy=1 in DONE, 0 from the next cycle.
//      Go IDLE.
//  - mem_we is 0 in every cycle that does not follow an accepted DATA word.
//  - abort=1 in any state: next cycle state=IDLE, in_ready=0, busy=0, no done
//    pulse. A write already registered still completes that cycle. err is unchanged.
//    abort has priority over start and over a simultaneous transfer.
//  - start together with abort in IDLE: abort wins and start is dropped.
//  - start while busy: ignored; no state change.
//  - words_loaded saturates at N and holds its value until the next start.
// CONFIGURATION
//  CHECKSUM_EN defined: running sum S = (sum of payload words) mod 2**DATA_W.
//    CSUM state accepts one more word C. C!=S sets err=1. Then go DONE.
//    C is never written to the buffer.
//  CHECKSUM_EN undefined: no CSUM state and no summing logic.
//    err is set only by an illegal header.
// TESTING
//  1 base=0x010, stream 3,0xAAAA,0x5555,0x1234 (valid=1 every cycle) -> writes
//    0x010/0xAAAA, 0x011/0x5555, 0x012/0x1234 on 3 consecutive cycles;
//    done pulses once; words_loaded=3; err=0.
//  2 header 0 or header MAX_WORDS+1 -> no mem_we; done pulses; err=1;
//    the next start with a valid header clears err.
//  3 base=2**ADDR_W-2, N=4 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001.
//  4 in_valid toggled randomly during N=8 -> exactly 8 writes at consecutive
//    addresses, in order; in_ready stays 1 until the last word.
//  5 abort after 2 of 5 payload words, with start held high -> 2 writes only;
//    IDLE next cycle; no done; a following start loads normally.
//    rst_n low mid-DATA -> all outputs 0 immediately.
//  6 CHECKSUM_EN, payload 0xFFFF,0x0002 -> checksum 0x0001 gives err=0;
//    checksum 0x0002 gives err=1. Both give 2 writes and 1 done.

Source files
------------

// File: rtl/dcnn_load_ctrl.sv
// Bulk loader: length header, payload words to buffer RAM from a base address.
// Optional trailing checksum word when CHECKSUM_EN is defined.
module dcnn_load_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 13,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_DONE
  } state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   len_q;
  logic              xfer;
  logic              hdr_bad;
  logic              last_word;

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
`endif

  assign xfer      = in_valid & in_ready;
  assign hdr_bad   = (in_data == '0) ||
                     (in_data > DATA_W'(MAX_WORDS));
  assign last_word = (words_loaded + 1'b1) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      len_q        <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
`ifdef CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      if (abort) begin
        // abort beats start and any transfer in this cycle
        state    <= S_IDLE;
        in_ready <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state        <= S_HDR;
              base_q       <= base_addr;
              err          <= 1'b0;
              words_loaded <= '0;
              in_ready     <= 1'b1;
              busy         <= 1'b1;
`ifdef CHECKSUM_EN
              sum_q        <= '0;
`endif
            end
          end
          S_HDR: begin
            if (xfer) begin
              if (hdr_bad) begin
                state    <= S_DONE;
                err      <= 1'b1;
                in_ready <= 1'b0;
                done     <= 1'b1;
              end else begin
                state <= S_DATA;
                len_q <= in_data[ADDR_W:0];
                idx_q <= '0;
              end
            end
          end
          S_DATA: begin
            if (xfer) begin
              mem_we       <= 1'b1;
              mem_addr     <= base_q + idx_q;
              mem_wdata    <= in_data;
              idx_q        <= idx_q + 1'b1;
              words_loaded <= words_loaded + 1'b1;
`ifdef CHECKSUM_EN
              sum_q        <= sum_q + in_data;
              if (last_word) state <= S_CSUM;
`else
              if (last_word) begin
                state    <= S_DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
              end
`endif
            end
          end
`ifdef CHECKSUM_EN
          S_CSUM: begin
            if (xfer) begin
              if (in_data != sum_q) err <= 1'b1;
              state    <= S_DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
`endif
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcnn_load_ctrl.sv
// Directed bench for dcnn_load_ctrl.
// Define CHECKSUM_EN to exercise the checksum variant.
module tb_dcnn_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [12:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [13:0] words_loaded;

  int checks = 0;
  int passes = 0;

  int          cyc = 0;
  int          wr_n = 0;
  int          done_n = 0;
  logic [12:0] wr_addr [256];
  logic [15:0] wr_data [256];
  int          wr_cyc  [256];

  always #5 clk = ~clk;

  dcnn_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we && wr_n < 256) begin
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_cyc[wr_n]  <= cyc;
    end
    if (mem_we) wr_n <= wr_n + 1;
    if (done) done_n <= done_n + 1;
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [12:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = w;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      $display("FAIL push_timeout got in_ready=0 want 1 word=%h", w);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_load(input logic [15:0] s);
`ifdef CHECKSUM_EN
    push(s);
`else
    if (s == 16'hx) $display("unused");
`endif
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err,
         words_loaded} !== '0)
      $display("FAIL reset_outputs got %h want 0",
               {in_ready, mem_we, mem_addr, mem_wdata, busy, done,
                err, words_loaded});
    else passes++;
    rst_n = 1'b1;
    settle(2);
  endtask

  task automatic test_basic;
    int w0, d0;
    logic [12:0] ea [3];
    logic [15:0] ed [3];
    ea = '{13'h010, 13'h011, 13'h012};
    ed = '{16'hAAAA, 16'h5555, 16'h1234};
    w0 = wr_n; d0 = done_n;
    do_start(13'h010);
    push(16'd3);
    for (int i = 0; i < 3; i++) push(ed[i]);
    finish_load(16'h1233);
    settle(3);
    checks++;
    if (wr_n - w0 !== 3)
      $display("FAIL basic_wr_count got %0d want 3", wr_n - w0);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[w0+i] !== ea[i] || wr_data[w0+i] !== ed[i])
        $display("FAIL basic_write%0d got %h/%h want %h/%h", i,
                 wr_addr[w0+i], wr_data[w0+i], ea[i], ed[i]);
      else passes++;
    end
    checks++;
    if (wr_cyc[w0+2] - wr_cyc[w0] !== 2)
      $display("FAIL basic_b2b got %0d want 2", wr_cyc[w0+2] - wr_cyc[w0]);
    else passes++;
    checks++;
    if (done_n - d0 !== 1)
      $display("FAIL basic_done got %0d want 1", done_n - d0);
    else passes++;
    checks++;
    if (words_loaded !== 14'd3 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_status got wl=%0d err=%b busy=%b want 3/0/0",
               words_loaded, err, busy);
    else passes++;
  endtask

  task automatic test_bad_header;
    int w0, d0;
    logic [15:0] hdrs [2];
    hdrs = '{16'd0, 16'd4097};
    for (int h = 0; h < 2; h++) begin
      w0 = wr_n; d0 = done_n;
      do_start(13'h000);
      push(hdrs[h]);
      settle(3);
      checks++;
      if (wr_n - w0 !== 0 || done_n - d0 !== 1 || err !== 1'b1)
        $display("FAIL bad_hdr%0d got wr=%0d done=%0d err=%b want 0/1/1",
                 h, wr_n - w0, done_n - d0, err);
      else passes++;
    end
    do_start(13'h100);
    checks++;
    if (err !== 1'b0)
      $display("FAIL err_clear_on_start got %b want 0", err);
    else passes++;
    push(16'd4096 - 16'd4095);
    push(16'h0007);
    finish_load(16'h0007);
    settle(3);
    checks++;
    if (err !== 1'b0 || words_loaded !== 14'd1)
      $display("FAIL good_after_bad got err=%b wl=%0d want 0/1",
               err, words_loaded);
    else passes++;
  endtask

  task automatic test_wrap;
    int w0;
    logic [12:0] ea [4];
    ea = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    w0 = wr_n;
    do_start(13'h1FFE);
    push(16'd4);
    for (int i = 0; i < 4; i++) push(16'(i + 1));
    finish_load(16'd10);
    settle(3);
    checks++;
    if (wr_n - w0 !== 4)
      $display("FAIL wrap_count got %0d want 4", wr_n - w0);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[w0+i] !== ea[i] || wr_data[w0+i] !== 16'(i + 1))
        $display("FAIL wrap_write%0d got %h/%h want %h/%h", i,
                 wr_addr[w0+i], wr_data[w0+i], ea[i], i + 1);
      else passes++;
    end
  endtask

  task automatic test_gaps;
    int w0, bad;
    int gaps [8];
    logic exp_rdy;
    gaps = '{0, 1, 2, 0, 1, 0, 3, 1};
    w0 = wr_n; bad = 0;
    do_start(13'h100);
    push(16'd8);
    for (int i = 0; i < 8; i++) begin
      push(16'h0100 + 16'(i));
      if (i < 7) begin
        for (int g = 0; g < gaps[i]; g++) begin
          if (!in_ready) bad++;
          @(negedge clk);
        end
        if (!in_ready) bad++;
      end
    end
`ifdef CHECKSUM_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    checks++;
    if (in_ready !== exp_rdy)
      $display("FAIL gaps_ready_after_last got %b want %b", in_ready, exp_rdy);
    else passes++;
    finish_load(16'h081C);
    settle(3);
    checks++;
    if (bad !== 0)
      $display("FAIL gaps_ready_held got %0d drops want 0", bad);
    else passes++;
    checks++;
    if (wr_n - w0 !== 8)
      $display("FAIL gaps_count got %0d want 8", wr_n - w0);
    else passes++;
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (wr_addr[w0+i] !== 13'h100 + 13'(i) ||
          wr_data[w0+i] !== 16'h0100 + 16'(i)) bad++;
    checks++;
    if (bad !== 0)
      $display("FAIL gaps_order got %0d bad writes want 0", bad);
    else passes++;
  endtask

  task automatic test_abort;
    int w0, d0;
    w0 = wr_n; d0 = done_n;
    do_start(13'h040);
    push(16'd5);
    push(16'hA000);
    push(16'hA001);
    abort = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hA002;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL abort_idle got busy=%b rdy=%b want 0/0", busy, in_ready);
    else passes++;
    abort = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    settle(3);
    checks++;
    if (wr_n - w0 !== 2 || done_n - d0 !== 0 || err !== 1'b0)
      $display("FAIL abort_effects got wr=%0d done=%0d err=%b want 2/0/0",
               wr_n - w0, done_n - d0, err);
    else passes++;
    w0 = wr_n; d0 = done_n;
    do_start(13'h050);
    push(16'd2);
    push(16'h0011);
    push(16'h0022);
    finish_load(16'h0033);
    settle(3);
    checks++;
    if (wr_n - w0 !== 2 || done_n - d0 !== 1 || words_loaded !== 14'd2 ||
        wr_addr[w0+1] !== 13'h051)
      $display("FAIL after_abort got wr=%0d done=%0d wl=%0d a=%h want 2/1/2/051",
               wr_n - w0, done_n - d0, words_loaded, wr_addr[w0+1]);
    else passes++;
  endtask

  task automatic test_reset_mid;
    do_start(13'h020);
    push(16'd4);
    push(16'hBEEF);
    checks++;
    if (mem_we !== 1'b1)
      $display("FAIL mid_write_pending got %b want 1", mem_we);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, err,
         words_loaded} !== '0)
      $display("FAIL reset_mid got %h want 0",
               {in_ready, mem_we, mem_addr, mem_wdata, busy, done,
                err, words_loaded});
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    settle(2);
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum;
    int w0, d0;
    logic [15:0] cs [2];
    logic ee [2];
    cs = '{16'h0001, 16'h0002};
    ee = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      w0 = wr_n; d0 = done_n;
      do_start(13'h200);
      push(16'd2);
      push(16'hFFFF);
      push(16'h0002);
      push(cs[k]);
      settle(3);
      checks++;
      if (err !== ee[k] || wr_n - w0 !== 2 || done_n - d0 !== 1)
        $display("FAIL csum%0d got err=%b wr=%0d done=%0d want %b/2/1",
                 k, err, wr_n - w0, done_n - d0, ee[k]);
      else passes++;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_bad_header;
    test_wrap;
    test_gaps;
    test_abort;
    test_reset_mid;
`ifdef CHECKSUM_EN
    test_checksum;
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
